uart_mmio_ctrl: RTL and testbench

Memory-mapped controller for the on-chip UART, placed between the CPU's memory/writeback stage and the `uart` instance. It decodes the 0x8000_xxxx I/O window and buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, so software store bursts do not stall on the serial line. It returns registered read data with one-cycle latency, matching the synchronous BIOS/DMEM read timing already used by the writeback mux.

---
 rtl/uart_mmio_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - memory-mapped UART controller with TX/RX byte FIFOs
//
// Decodes the 0x8000_xxxx I/O window, buffers CPU stores into a TX FIFO that
// drains into the UART transmitter, and buffers received bytes in an RX FIFO
// that the CPU pops through the rx data register. Load data is registered
// (one-cycle latency). Optional macro UART_MMIO_CYCLE_COUNTER_EN adds a
// free-running cycle counter at offsets 0x10 (read) / 0x18 (write clears).
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   mmio_addr/wdata/we/re    CPU access (byte address, store data, strobes)
//   mmio_rdata               registered load data
//   uart_tx_data_in*         byte stream towards the UART transmitter
//   uart_rx_data_out*        byte stream from the UART receiver

module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic        mmio_we,
  input  logic        mmio_re,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_tx_data_in,
  output logic        uart_tx_data_in_valid,
  input  logic        uart_tx_data_in_ready,
  input  logic [7:0]  uart_rx_data_out,
  input  logic        uart_rx_data_out_valid,
  output logic        uart_rx_data_out_ready
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wr, tx_rd;
  logic [TXW:0]   tx_count;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wr, rx_rd;
  logic [RXW:0]   rx_count;
  logic           tx_overflow;

  logic       hit;
  logic [4:0] off;
  logic       tx_full, tx_empty, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       wr_tx, wr_clr;
  logic [31:0] rdata_next;

  // Address bits between the window nibble and the register offset are not decoded.
  logic unused_bits;
  assign unused_bits = ^{mmio_addr[27:5], mmio_wdata[31:8]};

  assign hit = (mmio_addr[31:28] == 4'h8);
  assign off = mmio_addr[4:0];

  // All full/empty decisions come from start-of-cycle occupancy.
  assign tx_full  = (tx_count == TX_FULL);
  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);

  assign wr_tx  = mmio_we & hit & (off == 5'h08);
  assign wr_clr = mmio_we & hit & (off == 5'h0C);

  assign tx_push = wr_tx & ~tx_full;
  assign tx_pop  = uart_tx_data_in_valid & uart_tx_data_in_ready;
  assign rx_push = uart_rx_data_out_valid & uart_rx_data_out_ready;
  assign rx_pop  = mmio_re & hit & (off == 5'h04) & ~rx_empty;

  assign uart_tx_data_in_valid  = ~tx_empty;
  // Storage is not reset, so mask the head while empty to present 0.
  assign uart_tx_data_in        = tx_empty ? 8'h00 : tx_mem[tx_rd];
  assign uart_rx_data_out_ready = ~(rx_count == RX_FULL);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= mmio_wdata[7:0];
    if (rx_push) rx_mem[rx_wr] <= uart_rx_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TXW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TXW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TXW+1)'(1);
        2'b01:   tx_count <= tx_count - (TXW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RXW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RXW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RXW+1)'(1);
        2'b01:   rx_count <= rx_count - (RXW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tx_overflow <= 1'b0;
    else if (wr_clr)             tx_overflow <= 1'b0;
    else if (wr_tx && tx_full)   tx_overflow <= 1'b1;
  end

`ifdef UART_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cyc_cnt <= '0;
    else if (mmio_we && hit && off == 5'h18) cyc_cnt <= '0;
    else                                     cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  always_comb begin
    rdata_next = 32'h0;
    if (mmio_re && hit) begin
      case (off)
        5'h00: rdata_next = {29'd0, tx_overflow, ~rx_empty, ~tx_full};
        5'h04: rdata_next = rx_empty ? 32'h0 : {24'd0, rx_mem[rx_rd]};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
        5'h10: rdata_next = cyc_cnt;
`endif
        default: rdata_next = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mmio_rdata <= '0;
    else     mmio_rdata <= rdata_next;
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - self-checking bench for uart_mmio_ctrl

module tb_uart_mmio_ctrl;

  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic        mmio_we = 1'b0;
  logic        mmio_re = 1'b0;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready = 1'b0;
  logic [7:0]  uart_rx_data_out = '0;
  logic        uart_rx_data_out_valid = 1'b0;
  logic        uart_rx_data_out_ready;

  uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mmio_addr              (mmio_addr),
    .mmio_wdata             (mmio_wdata),
    .mmio_we                (mmio_we),
    .mmio_re                (mmio_re),
    .mmio_rdata             (mmio_rdata),
    .uart_tx_data_in        (uart_tx_data_in),
    .uart_tx_data_in_valid  (uart_tx_data_in_valid),
    .uart_tx_data_in_ready  (uart_tx_data_in_ready),
    .uart_rx_data_out       (uart_rx_data_out),
    .uart_rx_data_out_valid (uart_rx_data_out_valid),
    .uart_rx_data_out_ready (uart_rx_data_out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  emitted[$];
  logic        ovf_m = 1'b0;
  logic [31:0] cnt_m = '0;
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, starting just after a rising edge.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic txr, input logic rxv,
                      input logic [7:0] rxd);
    logic        hit;
    logic [4:0]  off;
    logic [31:0] exp_rd;
    logic        exp_txv, tx_pop, tx_push, rx_pop, rx_push;
    mmio_we = we; mmio_re = re; mmio_addr = addr; mmio_wdata = wdata;
    uart_tx_data_in_ready = txr; uart_rx_data_out_valid = rxv; uart_rx_data_out = rxd;
    #1;
    exp_txv = (tx_q.size() != 0);
    chk("tx_valid", {31'd0, uart_tx_data_in_valid}, {31'd0, exp_txv});
    chk("tx_data", {24'd0, uart_tx_data_in}, exp_txv ? {24'd0, tx_q[0]} : 32'h0);
    chk("rx_ready", {31'd0, uart_rx_data_out_ready}, {31'd0, rx_q.size() < RXD});
    hit = (addr[31:28] == 4'h8);
    off = addr[4:0];
    exp_rd = 32'h0;
    if (re && hit) begin
      if (off == 5'h00)
        exp_rd = {29'd0, ovf_m, rx_q.size() != 0, tx_q.size() < TXD};
      else if (off == 5'h04 && rx_q.size() != 0)
        exp_rd = {24'd0, rx_q[0]};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
      else if (off == 5'h10)
        exp_rd = cnt_m;
`endif
    end
    tx_pop  = exp_txv && txr;
    tx_push = we && hit && off == 5'h08 && tx_q.size() < TXD;
    rx_pop  = re && hit && off == 5'h04 && rx_q.size() != 0;
    rx_push = rxv && rx_q.size() < RXD;
    @(posedge clk);
    #1;
    chk("rdata", mmio_rdata, exp_rd);
    last_rd = mmio_rdata;
    if (we && hit && off == 5'h0C) ovf_m = 1'b0;
    else if (we && hit && off == 5'h08 && tx_q.size() >= TXD) ovf_m = 1'b1;
    if (tx_pop) begin emitted.push_back(tx_q[0]); void'(tx_q.pop_front()); end
    if (tx_push) tx_q.push_back(wdata[7:0]);
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rxd);
    if (we && hit && off == 5'h18) cnt_m = '0;
    else cnt_m = cnt_m + 32'd1;
  endtask

  task automatic idle(input logic txr);
    step(1'b0, 1'b0, 32'h0, 32'h0, txr, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    step(1'b1, 1'b0, addr, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b1, addr, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain_tx();
    for (int k = 0; k < 4 * TXD && tx_q.size() != 0; k++) idle(1'b1);
    chk("tx_drained", {31'd0, uart_tx_data_in_valid}, 32'h0);
  endtask

  initial begin
    // Reset then status
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", mmio_rdata, 32'h0);
    chk("rst_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
    chk("rst_tx_data", {24'd0, uart_tx_data_in}, 32'h0);
    chk("rst_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h1);
    rst = 1'b0;
    cnt_m = '0;
    rd(32'h8000_0000);
    chk("status_after_reset", last_rd, 32'h1);

    // TX overflow: nine bytes into eight entries with the transmitter stalled
    for (int i = 0; i < 9; i++) wr(32'h8000_0008, 32'h41 + i);
    rd(32'h8000_0000);
    chk("status_overflow", last_rd, 32'h4);
    emitted.delete();
    drain_tx();
    chk("tx_emit_count", emitted.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk("tx_emit_order", {24'd0, emitted[i]}, 32'h41 + i);
    wr(32'h8000_000C, 32'h0);
    rd(32'h8000_0000);
    chk("status_ovf_cleared", last_rd, 32'h1);

    // RX fill and backpressure
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h10 + 8'(i));
    chk("rx_ready_full", {31'd0, uart_rx_data_out_ready}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h18);
    for (int i = 0; i < 8; i++) begin
      rd(32'h8000_0004);
      chk("rx_read_order", last_rd, 32'h10 + i);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h18);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h19);
    rd(32'h8000_0004);
    chk("rx_read_18", last_rd, 32'h18);
    rd(32'h8000_0004);
    chk("rx_read_19", last_rd, 32'h19);
    rd(32'h8000_0004);
    chk("rx_read_empty", last_rd, 32'h0);

    // Empty-RX read with a simultaneous push returns 0 and keeps the byte
    step(1'b0, 1'b1, 32'h8000_0004, 32'h0, 1'b0, 1'b1, 8'h5A);
    chk("rx_empty_race", last_rd, 32'h0);
    rd(32'h8000_0004);
    chk("rx_race_kept", last_rd, 32'h5A);

    // Simultaneous RX pop and push while full
    for (int i = 0; i < RXD; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 32'h8000_0004, 32'h0, 1'b0, 1'b1, 8'hAA);
    chk("rx_ready_after_pop", {31'd0, uart_rx_data_out_ready}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'hAA);
    chk("rx_ready_refull", {31'd0, uart_rx_data_out_ready}, 32'h0);
    for (int i = 0; i < RXD; i++) rd(32'h8000_0004);
    chk("rx_last_is_aa", last_rd, 32'hAA);

    // Simultaneous TX write and UART pop while full
    for (int i = 0; i < TXD; i++) wr(32'h8000_0008, $urandom);
    step(1'b1, 1'b0, 32'h8000_0008, 32'h77, 1'b1, 1'b0, 8'h00);
    rd(32'h8000_0000);
    chk("status_full_race", last_rd, 32'h5);
    emitted.delete();
    drain_tx();
    chk("tx_race_emit_count", emitted.size(), 32'd7);
    wr(32'h8000_000C, 32'h0);

    // Decode
    wr(32'h4000_0008, 32'h55);
    wr(32'h8000_0014, 32'h66);
    chk("decode_no_push", {31'd0, uart_tx_data_in_valid}, 32'h0);
    rd(32'h4000_0008);
    chk("decode_miss_read", last_rd, 32'h0);
    rd(32'h8000_0014);
    chk("decode_unlisted_read", last_rd, 32'h0);

    // Reset mid-operation discards buffered bytes at once
    for (int i = 0; i < 3; i++) wr(32'h8000_0008, $urandom);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 8'h33);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
    chk("midrst_tx_data", {24'd0, uart_tx_data_in}, 32'h0);
    chk("midrst_rdata", mmio_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_q.delete(); rx_q.delete(); ovf_m = 1'b0; cnt_m = '0;
    rd(32'h8000_0000);
    chk("midrst_status", last_rd, 32'h1);

`ifdef UART_MMIO_CYCLE_COUNTER_EN
    wr(32'h8000_0018, 32'h0);
    repeat (4) idle(1'b0);
    rd(32'h8000_0010);
    chk("counter_n5", last_rd, 32'd4);
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    cnt_m = 32'hFFFF_FFFF;
    rd(32'h8000_0010);
    chk("counter_max", last_rd, 32'hFFFF_FFFF);
    rd(32'h8000_0010);
    chk("counter_wrap", last_rd, 32'h0);
`endif

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      logic [4:0]  offs [8];
      logic [31:0] a;
      offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h08};
      a = $urandom;
      a[4:0] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : offs[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) != 0) a[31:28] = 4'h8;
      else a[31:28] = 4'($urandom_range(0, 7));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
